nios_led_pio_arbiter: RTL
=========================

// Module: nios_led_pio_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single Avalon-MM slave of the LED PIO between
//  NUM_REQ on-chip requesters (CPU bridge, pattern sequencer, debug).
//  Serialises each request into one zero-wait PIO access.
//  Returns write-acks and read data to the owning requester.
//  Sits between the requesters and the PIO s1 port.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  ADDR_W   2   PIO register address width
//  DATA_W   32  PIO data width
// PORTS
//  clk            in   1               system clock, all logic rising-edge
//  reset          in   1               async, active-high; clears all state
//  req            in   NUM_REQ         per-requester request, held until ack
//  req_we         in   NUM_REQ         1=write, 0=read, per requester
//  req_addr       in   NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata      in   NUM_REQ*DATA_W  packed write data, same packing
//  gnt            out  NUM_REQ         one-hot owner, high ACCESS..RESP
//  ack            out  NUM_REQ         one-cycle completion pulse to owner
//  rdata          out  DATA_W          read data, valid with ack (broadcast)
//  pio_address    out  ADDR_W          to PIO address
//  pio_chipselect out  1               to PIO chipselect
//  pio_write_n    out  1               to PIO write_n (active-low)
//  pio_writedata  out  DATA_W          to PIO writedata
//  pio_readdata   in   DATA_W          from PIO readdata (combinational from address)
// BEHAVIOUR
//  Reset values: state=IDLE, gnt=0, ack=0, rdata=0, pio_chipselect=0, pio_write_n=1,
//   pio_address=0, pio_writedata=0, rr_ptr=0. Reset mid-access aborts; no ack issued.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE. Fixed 3-cycle transaction; max one
//   access per 3 clocks.
//  IDLE: if any req, select first set req[k] scanning k = rr_ptr, rr_ptr+1, ...
//   mod NUM_REQ. Register gnt, we, addr, wdata of winner; go ACCESS.
//   No req: stay IDLE, bus outputs idle.
//  ACCESS (1 cycle): pio_chipselect=1, pio_write_n=~we, pio_address/writedata
//   from latched values. On a read, capture pio_readdata at the clock edge
//   ending this cycle. Go RESP.
//  RESP (1 cycle): bus idle; ack[owner]=1; rdata=captured data (reads) or
//   unchanged (writes). rr_ptr <= owner+1, wrapping NUM_REQ-1 -> 0.
//   gnt cleared on exit; go IDLE.
//  Request inputs are sampled only in IDLE. Changes during ACCESS/RESP are ignored.
//  A req dropped mid-transaction still completes and is acked.
//  Requester must drop req within 1 cycle after ack or it is re-arbitrated as a new request.
//  Simultaneous requests: the round-robin order above decides. A single
//   requester with continuous req gets every slot (one per 3 clocks).
//  Exactly one pio_chipselect cycle per granted request; never two owners.
//  Latency req->ack: 3 clocks when idle (req seen cycle 0, ack in cycle 2).
// CONFIGURATION
//  PIO_ARB_LOCK_EN defined:
//   - Adds input req_lock[NUM_REQ].
//   - If the previous owner has req_lock=1 and req=1 in IDLE, it is re-granted
//     ahead of round-robin order.
//   - rr_ptr does not advance on a locked completion.
//   - Enables atomic read-modify-write of LED state.
//  PIO_ARB_LOCK_EN undefined: no req_lock port, pure round-robin.
// TESTING
//  1. Reset, then req[0] write addr 0 data 0xA5 -> one chipselect cycle with
//     write_n=0, writedata=0xA5; ack[0] 2 clocks after grant.
//  2. Read, PIO returning 0x3C -> rdata=0x3C with ack.
//  3. req=4'b1111 held -> grants 0,1,2,3,0 in order, one per 3 clocks, gnt always one-hot.
//  4. rr_ptr=3, req=4'b1001 -> grant 3 then 0 (wrap).
//  5. reset pulsed during ACCESS -> no ack, outputs at reset values, next grant from requester 0.
//  6. PIO_ARB_LOCK_EN: req0 locked, req1 pending -> req0 granted twice, then req1 after lock drops.

Source files
------------

// File: rtl/nios_led_pio_arbiter_if.sv
// Requester-side and PIO-side signals of the LED PIO arbiter, bundled per direction.
// The req_lock field exists only when PIO_ARB_LOCK_EN is defined.
interface nios_led_pio_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         pio_address;
    logic                      pio_chipselect;
    logic                      pio_write_n;
    logic [DATA_W-1:0]         pio_writedata;
    logic [DATA_W-1:0]         pio_readdata;

`ifdef PIO_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock;

    modport slave (
        input  req, req_we, req_addr, req_wdata, req_lock, pio_readdata,
        output gnt, ack, rdata, pio_address, pio_chipselect, pio_write_n, pio_writedata
    );
    modport master (
        output req, req_we, req_addr, req_wdata, req_lock, pio_readdata,
        input  gnt, ack, rdata, pio_address, pio_chipselect, pio_write_n, pio_writedata
    );
`else
    modport slave (
        input  req, req_we, req_addr, req_wdata, pio_readdata,
        output gnt, ack, rdata, pio_address, pio_chipselect, pio_write_n, pio_writedata
    );
    modport master (
        output req, req_we, req_addr, req_wdata, pio_readdata,
        input  gnt, ack, rdata, pio_address, pio_chipselect, pio_write_n, pio_writedata
    );
`endif
endinterface

// File: rtl/nios_led_pio_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one zero-wait LED PIO port.
// Define PIO_ARB_LOCK_EN to let a locked owner be re-granted for atomic read-modify-write.
module nios_led_pio_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 32
) (
    input  logic clk,
    input  logic reset,
    nios_led_pio_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                cs_q, cs_d;
    logic                write_n_q, write_n_d;
`ifdef PIO_ARB_LOCK_EN
    logic                lock_q, lock_d;
    logic                prev_vld_q, prev_vld_d;
`endif

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
    end

    // Winner search: first asserted req starting at rr_q, wrapping at NUM_REQ.
    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    int               j;

    // NOTE: always_comb uses blocking '=' and gives every output a default first,
    // so no path leaves a value held over and no latch is inferred.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            cand = IDX_W'(j);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
`ifdef PIO_ARB_LOCK_EN
        if (prev_vld_q && bus.req[owner_q] && bus.req_lock[owner_q]) begin
            found = 1'b1;
            win   = owner_q;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        rdata_d   = rdata_q;
        addr_d    = '0;
        wdata_d   = '0;
        cs_d      = 1'b0;
        write_n_d = 1'b1;
`ifdef PIO_ARB_LOCK_EN
        lock_d     = lock_q;
        prev_vld_d = prev_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = ACCESS;
                    owner_d   = win;
                    gnt_d     = NUM_REQ'(1) << win;
                    cs_d      = 1'b1;
                    write_n_d = ~bus.req_we[win];
                    addr_d    = addr_arr[win];
                    wdata_d   = wdata_arr[win];
`ifdef PIO_ARB_LOCK_EN
                    lock_d     = bus.req_lock[win];
                    prev_vld_d = 1'b1;
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
                ack_d   = gnt_q;
                if (write_n_q) rdata_d = bus.pio_readdata;
            end
            RESP: begin
                state_d = IDLE;
                gnt_d   = '0;
                rr_d    = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + IDX_W'(1);
`ifdef PIO_ARB_LOCK_EN
                if (lock_q) rr_d = rr_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_q      <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
`ifdef PIO_ARB_LOCK_EN
            lock_q     <= 1'b0;
            prev_vld_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cs_q      <= cs_d;
            write_n_q <= write_n_d;
`ifdef PIO_ARB_LOCK_EN
            lock_q     <= lock_d;
            prev_vld_q <= prev_vld_d;
`endif
        end
    end

    assign bus.gnt            = gnt_q;
    assign bus.ack            = ack_q;
    assign bus.rdata          = rdata_q;
    assign bus.pio_address    = addr_q;
    assign bus.pio_writedata  = wdata_q;
    assign bus.pio_chipselect = cs_q;
    assign bus.pio_write_n    = write_n_q;

endmodule
